// File: rtl/fwd_hazard_scoreboard_pkg.sv
// Shared types and helpers for the forwarding/hazard scoreboard.
// Purely declarative: no latency, no backpressure.
package fwd_hazard_scoreboard_pkg;

  localparam int REG_AW_DEF  = 5;
  localparam int DEPTH_DEF   = 3;
  localparam int LAT_W_DEF   = 2;
  localparam int FWD_REGFILE = 0;
  localparam int SELW        = $clog2(DEPTH_DEF + 1);

  typedef struct packed {
    logic                  valid;
    logic [REG_AW_DEF-1:0] rd;
    logic [LAT_W_DEF-1:0]  lat;
  } slot_t;

  function automatic int sel_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // A zero latency still needs one cycle to land in slot 0; beyond DEPTH the
  // producer has left the window, so waiting longer than DEPTH is meaningless.
  function automatic int norm_lat(input int lat, input int depth);
    if (lat == 0) return 1;
    if (lat > depth) return depth;
    return lat;
  endfunction

endpackage

// File: rtl/fwd_hazard_scoreboard_port_select.sv
// Per-read-port forwarding source picker: youngest matching slot wins.
// Combinational (0 cycles); raises hazard_o when that producer is not yet ready.
module fwd_port_select
  import fwd_hazard_scoreboard_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int LAT_W  = LAT_W_DEF
) (
  input  logic [DEPTH-1:0]        slot_vld_i,
  input  logic [DEPTH*REG_AW-1:0] slot_rd_i,
  input  logic [DEPTH*LAT_W-1:0]  slot_lat_i,
  input  logic [REG_AW-1:0]       rs_i,
  input  logic                    rs_used_i,
  output logic [sel_w(DEPTH)-1:0] sel_o,
  output logic                    hazard_o
);

  localparam int SW = sel_w(DEPTH);

  // Walk oldest to youngest so the youngest match overwrites any older one.
  always_comb begin
    sel_o    = SW'(FWD_REGFILE);
    hazard_o = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (rs_used_i && slot_vld_i[k] && (slot_rd_i[k*REG_AW +: REG_AW] == rs_i)
          && (rs_i != '0)) begin
        if ((k + 1) >= int'(slot_lat_i[k*LAT_W +: LAT_W])) begin
          sel_o    = SW'(k + 1);
          hazard_o = 1'b0;
        end else begin
          sel_o    = SW'(FWD_REGFILE);
          hazard_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_scoreboard.sv
// Tracks in-flight writers from EX onward, registers per-port forwarding selects.
// FWD_SEL has 1 cycle latency (aligned to EX); STALL is combinational and holds IF/ID.
module fwd_hazard_scoreboard
  import fwd_hazard_scoreboard_pkg::*;
#(
  parameter int REG_AW       = REG_AW_DEF,
  parameter int NUM_RD_PORTS = 2,
  parameter int DEPTH        = DEPTH_DEF,
  parameter int LAT_W        = LAT_W_DEF,
  parameter int CNT_W        = 16
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  ID_VALID,
  input  logic [NUM_RD_PORTS*REG_AW-1:0]        ID_RS,
  input  logic [NUM_RD_PORTS-1:0]               ID_RS_USED,
  input  logic [REG_AW-1:0]                     ID_RD,
  input  logic                                  ID_REGWRITE,
  input  logic [LAT_W-1:0]                      ID_LAT,
  input  logic                                  FLUSH,
  output logic                                  STALL,
  output logic [NUM_RD_PORTS*sel_w(DEPTH)-1:0]  FWD_SEL,
  output logic [CNT_W-1:0]                      STALL_CNT
);

  localparam int SW = sel_w(DEPTH);

  logic [DEPTH-1:0]           slot_vld_q, slot_vld_d;
  logic [DEPTH*REG_AW-1:0]    slot_rd_q,  slot_rd_d;
  logic [DEPTH*LAT_W-1:0]     slot_lat_q, slot_lat_d;
  logic [NUM_RD_PORTS*SW-1:0] sel_next, fwd_sel_q, fwd_sel_d;
  logic [NUM_RD_PORTS-1:0]    hazard;
  logic [CNT_W-1:0]           stall_cnt_q, stall_cnt_d;

  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
    fwd_port_select #(
      .REG_AW (REG_AW),
      .DEPTH  (DEPTH),
      .LAT_W  (LAT_W)
    ) u_sel (
      .slot_vld_i (slot_vld_q),
      .slot_rd_i  (slot_rd_q),
      .slot_lat_i (slot_lat_q),
      .rs_i       (ID_RS[p*REG_AW +: REG_AW]),
      .rs_used_i  (ID_RS_USED[p]),
      .sel_o      (sel_next[p*SW +: SW]),
      .hazard_o   (hazard[p])
    );
  end

  assign STALL = ID_VALID & (|hazard);

  always_comb begin
    slot_vld_d = slot_vld_q;
    slot_rd_d  = slot_rd_q;
    slot_lat_d = slot_lat_q;
    slot_vld_d[0]          = ID_VALID & ID_REGWRITE & (ID_RD != '0) & ~STALL & ~FLUSH;
    slot_rd_d[0 +: REG_AW] = ID_RD;
    slot_lat_d[0 +: LAT_W] = LAT_W'(norm_lat(int'(ID_LAT), DEPTH));
    for (int k = 1; k < DEPTH; k++) begin
      slot_vld_d[k]                = slot_vld_q[k-1];
      slot_rd_d[k*REG_AW +: REG_AW] = slot_rd_q[(k-1)*REG_AW +: REG_AW];
      slot_lat_d[k*LAT_W +: LAT_W]  = slot_lat_q[(k-1)*LAT_W +: LAT_W];
    end
  end

  // A bubble or a killed instruction in EX must not forward from anywhere.
  always_comb begin
    fwd_sel_d   = (STALL | FLUSH) ? '0 : sel_next;
    stall_cnt_d = stall_cnt_q;
    if (STALL && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_vld_q  <= '0;
      slot_rd_q   <= '0;
      slot_lat_q  <= '0;
      fwd_sel_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      slot_vld_q  <= slot_vld_d;
      slot_rd_q   <= slot_rd_d;
      slot_lat_q  <= slot_lat_d;
      fwd_sel_q   <= fwd_sel_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign FWD_SEL   = fwd_sel_q;
  assign STALL_CNT = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Directed bench for fwd_hazard_scoreboard with hand-computed expectations.
module tb_fwd_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ID_VALID;
  logic [9:0]  ID_RS;
  logic [1:0]  ID_RS_USED;
  logic [4:0]  ID_RD;
  logic        ID_REGWRITE;
  logic [1:0]  ID_LAT;
  logic        FLUSH;
  logic        STALL;
  logic [3:0]  FWD_SEL;
  logic [15:0] STALL_CNT;

  int n_chk = 0;
  int n_err = 0;

  fwd_hazard_scoreboard dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ID_VALID    (ID_VALID),
    .ID_RS       (ID_RS),
    .ID_RS_USED  (ID_RS_USED),
    .ID_RD       (ID_RD),
    .ID_REGWRITE (ID_REGWRITE),
    .ID_LAT      (ID_LAT),
    .FLUSH       (FLUSH),
    .STALL       (STALL),
    .FWD_SEL     (FWD_SEL),
    .STALL_CNT   (STALL_CNT)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    ID_VALID = 1'b0; ID_RS = '0; ID_RS_USED = '0;
    ID_RD = '0; ID_REGWRITE = 1'b0; ID_LAT = '0; FLUSH = 1'b0;
  endtask

  task automatic drive_issue(input logic [4:0] rd, input logic [1:0] lat);
    drive_idle();
    ID_VALID = 1'b1; ID_REGWRITE = 1'b1; ID_RD = rd; ID_LAT = lat;
  endtask

  task automatic drive_use(input logic [4:0] rs1, input logic [4:0] rs2, input logic [1:0] used);
    drive_idle();
    ID_VALID = 1'b1; ID_RS = {rs2, rs1}; ID_RS_USED = used;
  endtask

  task automatic drain();
    drive_idle();
    for (int i = 0; i < 4; i++) tick();
  endtask

  initial begin
    drive_idle();
    rst_n = 1'b0;
    #12;
    check_eq("reset_stall",  STALL, 0);
    check_eq("reset_sel",    FWD_SEL, 0);
    check_eq("reset_cnt",    STALL_CNT, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // ALU back-to-back
    drive_issue(5'd5, 2'd1); tick();
    drive_use(5'd5, 5'd0, 2'b01); #1;
    check_eq("alu_stall", STALL, 0);
    tick();
    check_eq("alu_sel", FWD_SEL, 4'b0001);
    drain();

    // latency 0 behaves like latency 1
    drive_issue(5'd10, 2'd0); tick();
    drive_use(5'd10, 5'd0, 2'b01); #1;
    check_eq("lat0_stall", STALL, 0);
    tick();
    check_eq("lat0_sel", FWD_SEL, 4'b0001);
    drain();

    // load-use on port 1
    drive_issue(5'd6, 2'd2); tick();
    drive_use(5'd0, 5'd6, 2'b10); #1;
    check_eq("lu_stall", STALL, 1);
    tick();
    check_eq("lu_bubble", dut.slot_vld_q[0], 0);
    check_eq("lu_sel_bubble", FWD_SEL, 0);
    check_eq("lu_cnt", STALL_CNT, 1);
    check_eq("lu_stall_drop", STALL, 0);
    tick();
    check_eq("lu_sel", FWD_SEL, 4'b1000);
    drain();

    // multi-cycle latency 3
    drive_issue(5'd9, 2'd3); tick();
    drive_use(5'd9, 5'd0, 2'b01); #1;
    check_eq("mc_stall0", STALL, 1);
    tick();
    check_eq("mc_stall1", STALL, 1);
    tick();
    check_eq("mc_stall2", STALL, 0);
    check_eq("mc_cnt", STALL_CNT, 3);
    tick();
    check_eq("mc_sel", FWD_SEL, 4'b0011);
    drain();

    // WAW: youngest wins on both ports
    drive_issue(5'd7, 2'd1); tick();
    drive_issue(5'd7, 2'd1); tick();
    drive_use(5'd7, 5'd7, 2'b11); #1;
    check_eq("waw_stall", STALL, 0);
    tick();
    check_eq("waw_sel", FWD_SEL, 4'b0101);
    drain();

    // WAW: young slow producer stalls even though older one is ready
    drive_issue(5'd8, 2'd1); tick();
    drive_issue(5'd8, 2'd2); tick();
    drive_use(5'd8, 5'd0, 2'b01); #1;
    check_eq("waw_slow_stall", STALL, 1);
    tick();
    check_eq("waw_slow_drop", STALL, 0);
    tick();
    check_eq("waw_slow_sel", FWD_SEL, 4'b0010);
    check_eq("waw_slow_cnt", STALL_CNT, 4);
    drain();

    // x0 never forwards
    drive_issue(5'd0, 2'd1); tick();
    drive_use(5'd0, 5'd0, 2'b01); #1;
    check_eq("x0_stall", STALL, 0);
    tick();
    check_eq("x0_sel", FWD_SEL, 0);
    drain();

    // unused port ignores a live, not-ready producer
    drive_issue(5'd12, 2'd2); tick();
    drive_use(5'd12, 5'd12, 2'b00); #1;
    check_eq("unused_stall", STALL, 0);
    tick();
    check_eq("unused_sel", FWD_SEL, 0);
    drain();

    // flushed producer is never tracked
    drive_issue(5'd13, 2'd1); FLUSH = 1'b1; tick();
    drive_use(5'd13, 5'd0, 2'b01); #1;
    check_eq("flush_stall", STALL, 0);
    tick();
    check_eq("flush_sel", FWD_SEL, 0);
    drain();

    // FLUSH does not mask STALL, and zeroes the select
    drive_issue(5'd14, 2'd2); tick();
    drive_use(5'd14, 5'd0, 2'b01); FLUSH = 1'b1; #1;
    check_eq("flush_keeps_stall", STALL, 1);
    tick();
    check_eq("flush_stall_sel", FWD_SEL, 0);
    check_eq("flush_stall_cnt", STALL_CNT, 5);
    drain();

    // asynchronous reset in the middle of a stall
    drive_issue(5'd15, 2'd3); tick();
    drive_use(5'd15, 5'd0, 2'b01); #1;
    check_eq("rst_pre_stall", STALL, 1);
    tick();
    check_eq("rst_pre_cnt", STALL_CNT, 6);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_async_stall", STALL, 0);
    check_eq("rst_async_sel", FWD_SEL, 0);
    check_eq("rst_async_cnt", STALL_CNT, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("rst_post_stall", STALL, 0);
    tick();
    check_eq("rst_post_sel", FWD_SEL, 0);
    check_eq("rst_post_cnt", STALL_CNT, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
